// File: rtl/universal_reg.sv
// universal_reg: parametrised general-purpose datapath register.
// Supports hold, serial shift left/right, parallel load, increment,
// decrement and rotate left/right, with a synchronous clear and an
// enable. A registered flag captures the carry, borrow or the bit shifted
// or rotated out.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous active-low reset (A = RESET_VAL, c = 0)
//   clr    - synchronous clear, overrides en and mode
//   en     - operation enable, 0 holds A and c
//   mode   - operation select
//   I      - parallel load data
//   sr_in  - serial bit entering the MSB on shift right
//   sl_in  - serial bit entering the LSB on shift left
//   A      - register contents (registered)
//   c      - carry/borrow/shift-out flag (registered)
//   zero   - combinational, 1 when A == 0
module universal_reg #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] A,
  output logic             c,
  output logic             zero
);

  localparam int unsigned WIDTH_EXT = WIDTH + 1;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_INC  = 3'b100;
  localparam logic [2:0] MODE_DEC  = 3'b101;
  localparam logic [2:0] MODE_ROR  = 3'b110;
  localparam logic [2:0] MODE_ROL  = 3'b111;

  logic [WIDTH-1:0] a_q, a_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   inc_sum;

  // Next-state selection: clr beats en, en beats mode.
  always_comb begin
    a_d     = a_q;
    c_d     = c_q;
    // One bit wider so the wrap from all-ones lands in the carry.
    inc_sum = {1'b0, a_q} + WIDTH_EXT'(1);
    if (clr) begin
      a_d = '0;
      c_d = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          a_d = a_q;
          c_d = c_q;
        end
        MODE_SHR: begin
          a_d = {sr_in, a_q[WIDTH-1:1]};
          c_d = a_q[0];
        end
        MODE_SHL: begin
          a_d = {a_q[WIDTH-2:0], sl_in};
          c_d = a_q[WIDTH-1];
        end
        MODE_LOAD: begin
          a_d = I;
          c_d = 1'b0;
        end
        MODE_INC: begin
          a_d = inc_sum[WIDTH-1:0];
          c_d = inc_sum[WIDTH];
        end
        MODE_DEC: begin
          a_d = a_q - WIDTH'(1);
          // Borrow only when wrapping from zero to all-ones.
          c_d = (a_q == '0);
        end
        MODE_ROR: begin
          a_d = {a_q[0], a_q[WIDTH-1:1]};
          c_d = a_q[0];
        end
        MODE_ROL: begin
          a_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
          c_d = a_q[WIDTH-1];
        end
      endcase
    end
  end

  // State register with asynchronous reset to RESET_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= RESET_VAL;
      c_q <= 1'b0;
    end else begin
      a_q <= a_d;
      c_q <= c_d;
    end
  end

  assign A    = a_q;
  assign c    = c_q;
  assign zero = (a_q == '0);

endmodule

// File: tb/tb_universal_reg.sv
// Directed self-checking bench for universal_reg: a 4-bit instance with
// RESET_VAL = 0 and an 8-bit instance with RESET_VAL = 8'hA5.
module tb_universal_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_INC  = 3'b100;
  localparam logic [2:0] M_DEC  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_ROL  = 3'b111;

  logic       clk;
  int         checks;
  int         errors;

  // 4-bit instance signals
  logic       rst4, clr4, en4, sr4, sl4;
  logic [2:0] mode4;
  logic [3:0] i4, a4;
  logic       c4, z4;

  // 8-bit instance signals
  logic       rst8, clr8, en8, sr8, sl8;
  logic [2:0] mode8;
  logic [7:0] i8, a8;
  logic       c8, z8;

  universal_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .rst(rst4), .clr(clr4), .en(en4), .mode(mode4), .I(i4),
    .sr_in(sr4), .sl_in(sl4), .A(a4), .c(c4), .zero(z4)
  );

  universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst8), .clr(clr8), .en(en8), .mode(mode8), .I(i8),
    .sr_in(sr8), .sl_in(sl8), .A(a8), .c(c8), .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b0; clr4 = 1'b0; en4 = 1'b0; mode4 = M_HOLD; i4 = 4'h0;
    sr4 = 1'b0; sl4 = 1'b0;
    tick();
    tick();
    checks++; if (a4 !== 4'b0000) begin errors++; $display("FAIL reset_A got %b exp 0000", a4); end
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL reset_c got %b exp 0", c4); end
    checks++; if (z4 !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", z4); end
  endtask

  task automatic test_load();
    rst4 = 1'b1; en4 = 1'b1; mode4 = M_LOAD; i4 = 4'b1010;
    tick();
    checks++; if (a4 !== 4'b1010) begin errors++; $display("FAIL load_A got %b exp 1010", a4); end
    checks++; if (z4 !== 1'b0) begin errors++; $display("FAIL load_zero got %b exp 0", z4); end
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL load_c got %b exp 0", c4); end
  endtask

  task automatic test_async_reset();
    en4 = 1'b0; mode4 = M_HOLD;
    #2;
    rst4 = 1'b0;
    #1;
    checks++; if (a4 !== 4'b0000) begin errors++; $display("FAIL async_reset_A got %b exp 0000", a4); end
    checks++; if (z4 !== 1'b1) begin errors++; $display("FAIL async_reset_zero got %b exp 1", z4); end
    #1;
    rst4 = 1'b1;
  endtask

  task automatic test_shifts();
    en4 = 1'b1; mode4 = M_LOAD; i4 = 4'b1011;
    tick();
    mode4 = M_SHR; sr4 = 1'b0;
    tick();
    checks++; if (a4 !== 4'b0101) begin errors++; $display("FAIL shr_A got %b exp 0101", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL shr_c got %b exp 1", c4); end
    mode4 = M_SHL; sl4 = 1'b1;
    tick();
    checks++; if (a4 !== 4'b1011) begin errors++; $display("FAIL shl_A got %b exp 1011", a4); end
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL shl_c got %b exp 0", c4); end
    mode4 = M_ROR;
    tick();
    checks++; if (a4 !== 4'b1101) begin errors++; $display("FAIL ror_A got %b exp 1101", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL ror_c got %b exp 1", c4); end
    mode4 = M_ROL;
    tick();
    checks++; if (a4 !== 4'b1011) begin errors++; $display("FAIL rol_A got %b exp 1011", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL rol_c got %b exp 1", c4); end
    mode4 = M_SHR; sr4 = 1'b1;
    tick();
    checks++; if (a4 !== 4'b1101) begin errors++; $display("FAIL shr_in1_A got %b exp 1101", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL shr_in1_c got %b exp 1", c4); end
  endtask

  task automatic test_hold();
    mode4 = M_HOLD;
    tick();
    checks++; if (a4 !== 4'b1101) begin errors++; $display("FAIL hold_mode_A got %b exp 1101", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL hold_mode_c got %b exp 1", c4); end
    en4 = 1'b0; mode4 = M_INC;
    tick();
    checks++; if (a4 !== 4'b1101) begin errors++; $display("FAIL hold_en_A got %b exp 1101", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL hold_en_c got %b exp 1", c4); end
  endtask

  task automatic test_counter();
    en4 = 1'b1; mode4 = M_LOAD; i4 = 4'b1110;
    tick();
    mode4 = M_INC;
    tick();
    checks++; if (a4 !== 4'b1111) begin errors++; $display("FAIL inc1_A got %b exp 1111", a4); end
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL inc1_c got %b exp 0", c4); end
    tick();
    checks++; if (a4 !== 4'b0000) begin errors++; $display("FAIL inc2_A got %b exp 0000", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL inc2_c got %b exp 1", c4); end
    checks++; if (z4 !== 1'b1) begin errors++; $display("FAIL inc2_zero got %b exp 1", z4); end
    mode4 = M_DEC;
    tick();
    checks++; if (a4 !== 4'b1111) begin errors++; $display("FAIL dec1_A got %b exp 1111", a4); end
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL dec1_c got %b exp 1", c4); end
    tick();
    checks++; if (a4 !== 4'b1110) begin errors++; $display("FAIL dec2_A got %b exp 1110", a4); end
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL dec2_c got %b exp 0", c4); end
  endtask

  task automatic test_priority();
    en4 = 1'b0; mode4 = M_LOAD; i4 = 4'b0011;
    tick();
    checks++; if (a4 !== 4'b1110) begin errors++; $display("FAIL prio_en0_A got %b exp 1110", a4); end
    // Put a 1 in c so the clear has something to reset.
    en4 = 1'b1; mode4 = M_ROR;
    tick();
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL prio_ror_c got %b exp 0", c4); end
    mode4 = M_ROR;
    tick();
    checks++; if (c4 !== 1'b1) begin errors++; $display("FAIL prio_ror2_c got %b exp 1", c4); end
    clr4 = 1'b1; en4 = 1'b1; mode4 = M_LOAD; i4 = 4'b0011;
    tick();
    checks++; if (a4 !== 4'b0000) begin errors++; $display("FAIL prio_clr_A got %b exp 0000", a4); end
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL prio_clr_c got %b exp 0", c4); end
    clr4 = 1'b0;
    tick();
    checks++; if (a4 !== 4'b0011) begin errors++; $display("FAIL prio_load_A got %b exp 0011", a4); end
    // Inputs changed between edges count only at the edge.
    i4 = 4'b0101;
    #3;
    i4 = 4'b0110;
    tick();
    checks++; if (a4 !== 4'b0110) begin errors++; $display("FAIL sample_edge_A got %b exp 0110", a4); end
  endtask

  task automatic test_width8();
    logic [7:0] exp_a;
    logic       exp_c;
    checks++; if (a8 !== 8'hA5) begin errors++; $display("FAIL w8_reset_A got %h exp a5", a8); end
    checks++; if (c8 !== 1'b0) begin errors++; $display("FAIL w8_reset_c got %b exp 0", c8); end
    rst8 = 1'b1; en8 = 1'b1; mode8 = M_INC;
    // 0xA5 + 91 = 0x100: wraps on the 91st increment.
    for (int k = 1; k <= 91; k++) begin
      tick();
      exp_a = 8'(8'hA5 + k);
      exp_c = (k == 91);
      checks++; if (a8 !== exp_a || c8 !== exp_c) begin
        errors++; $display("FAIL w8_inc_%0d got %h/%b exp %h/%b", k, a8, c8, exp_a, exp_c);
      end
    end
    checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL w8_wrap_zero got %b exp 1", z8); end
    mode8 = M_LOAD; i8 = 8'h81;
    tick();
    mode8 = M_ROL;
    exp_a = 8'h81;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_c = exp_a[7];
      exp_a = {exp_a[6:0], exp_a[7]};
      checks++; if (a8 !== exp_a || c8 !== exp_c) begin
        errors++; $display("FAIL w8_rol_%0d got %h/%b exp %h/%b", k, a8, c8, exp_a, exp_c);
      end
    end
    checks++; if (a8 !== 8'h81) begin errors++; $display("FAIL w8_rol_final got %h exp 81", a8); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst8 = 1'b0; clr8 = 1'b0; en8 = 1'b0; mode8 = M_HOLD; i8 = 8'h00;
    sr8 = 1'b0; sl8 = 1'b0;
    test_reset();
    test_load();
    test_async_reset();
    test_shifts();
    test_hold();
    test_counter();
    test_priority();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_reg.md
# universal_reg

Parametrised universal register: the next generation of the team's 4-bit load register. It adds configurable width, a synchronous clear, an enable, serial shift left/right, rotate, increment/decrement and a registered carry/shift-out flag. It is a general datapath register used by counter, shifter and accumulator blocks.

## Interface

- WIDTH, 4, register width in bits (≥2)
- RESET_VAL, 0, value loaded into A on reset (WIDTH bits)

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear; overrides en and mode
- en  input  1  operation enable; 0 = hold everything
- mode  input  3  operation select (see Operation)
- I  input  WIDTH  parallel load data
- sr_in  input  1  serial bit entering the MSB on shift right
- sl_in  input  1  serial bit entering the LSB on shift left
- A  output  WIDTH  register contents
- c  output  1  registered carry/borrow/shifted-out bit
- zero  output  1  combinational, 1 when A == 0

## Operation

- Reset (rst=0, asynchronous): A = RESET_VAL and c = 0 immediately, independent of clk. Both are held while rst=0.
- Priority at each rising edge after reset: clr > en > mode.
- clr=1: A <= 0, c <= 0, regardless of en and mode.
- en=0 (clr=0): A and c hold.
- en=1, by mode:
  - 000 hold: A and c unchanged.
  - 001 shift right: A <= {sr_in, A[WIDTH-1:1]}, c <= A[0].
  - 010 shift left: A <= {A[WIDTH-2:0], sl_in}, c <= A[WIDTH-1].
  - 011 load: A <= I, c <= 0.
  - 100 increment: {c, A} <= A + 1, computed WIDTH+1 wide. c=1 only on wrap from all-ones to 0.
  - 101 decrement: A <= A − 1 modulo 2^WIDTH. c <= 1 only on wrap from 0 to all-ones (borrow).
  - 110 rotate right: A <= {A[0], A[WIDTH-1:1]}, c <= A[0].
  - 111 rotate left: A <= {A[WIDTH-2:0], A[WIDTH-1]}, c <= A[WIDTH-1].
- zero is derived from the registered A only. It has no dependence on inputs.
- Arithmetic is unsigned and modulo 2^WIDTH. No saturation.
- X on mode while en=1 and clr=0 is illegal. The bench must not drive it.

## Timing

- Latency: one clock. Inputs sampled at rising edge N appear on A and c after edge N.
- A and c are registered outputs. zero follows A combinationally within the same cycle.
- Serial inputs, I and mode are sampled only at the rising edge. Changes between edges have no effect.
- Reset mid-operation: asserting rst at any time forces A=RESET_VAL and c=0 without waiting for an edge. Any in-flight operation is discarded.
- Reset release: the first operation occurs at the first rising edge where rst=1. Release coincident with an edge takes effect at the following edge.
- clr and load in the same cycle: clr wins, A=0.
- Back-to-back operations are allowed every cycle. No handshake and no idle cycles are required.
- c from a shift/rotate/inc/dec is valid for exactly the cycle(s) until the next enabled operation, clear or reset. It is held across en=0 and mode=000.

## Test plan

- Reset/load (WIDTH=4, RESET_VAL=0):
  - Hold rst=0 for 2 edges; A=0000, c=0, zero=1.
  - Release rst, load I=1010 → A=1010 after 1 edge, zero=0.
  - Assert rst mid-cycle between edges → A=0000 immediately.
- Shifts:
  - From A=1011, shift right with sr_in=0 → A=0101, c=1.
  - Then shift left with sl_in=1 → A=1011, c=0.
  - Then rotate right → A=1101, c=1.
- Counter wrap:
  - Load 1110, increment ×2 → A=1111 (c=0), then A=0000 (c=1, zero=1).
  - Decrement once → A=1111, c=1.
- Priority:
  - en=0 with mode=011, I=0011 → A unchanged.
  - clr=1 with en=1, mode=011, I=0011 → A=0000, c=0.
  - en=1, clr=0 → A=0011.
- Parameter sweep: WIDTH=8, RESET_VAL=8'hA5.
  - Reset → A=A5.
  - Increment 91 times → A=00, c=1 on that edge.
  - Rotate left 8 times from 81 → A=81, with c matching the rotated bit each cycle.
